// File: rtl/riscv_pkg.sv
// Core-wide constants for the integer register file and its users.
package riscv_pkg;
    localparam int XLEN    = 32;
    localparam int NR_XREG = 32;
    localparam int XREG_AW = 5;
    localparam int X0_IDX  = 0;
endpackage

// File: rtl/regfile_sb_if.sv
// Read, writeback, issue and flush bundle between the pipeline and regfile_sb.
interface regfile_sb_if
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int NR_REG     = NR_XREG,
    parameter int ADDR_W     = XREG_AW,
    parameter int NR_RD      = 2
);
    logic [NR_RD*ADDR_W-1:0]     rd_addr;
    logic [NR_RD*DATA_WIDTH-1:0] rd_data;
    logic [NR_RD-1:0]            rd_pending;
    logic                        wa_en;
    logic [ADDR_W-1:0]           wa_addr;
    logic [DATA_WIDTH-1:0]       wa_data;
    logic                        wb_en;
    logic [ADDR_W-1:0]           wb_addr;
    logic [DATA_WIDTH-1:0]       wb_data;
    logic                        iss_en;
    logic [ADDR_W-1:0]           iss_addr;
    logic                        flush;
    logic                        any_pending;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               iss_en, iss_addr, flush,
        input  rd_data, rd_pending, any_pending
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               iss_en, iss_addr, flush,
        output rd_data, rd_pending, any_pending
    );
endinterface

// File: rtl/regfile_bypass_mux.sv
// One read port: x0 / writeback-A / writeback-B / stored-value priority mux
// and pending qualification against same-cycle writebacks.
module regfile_bypass_mux
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_W     = XREG_AW
) (
    input  logic [ADDR_W-1:0]     i_rd_addr,
    input  logic                  i_wa_en,
    input  logic [ADDR_W-1:0]     i_wa_addr,
    input  logic [DATA_WIDTH-1:0] i_wa_data,
    input  logic                  i_wb_en,
    input  logic [ADDR_W-1:0]     i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    input  logic [DATA_WIDTH-1:0] i_stored,
    input  logic                  i_pending,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_pending
);
    logic w_is_x0;
    logic w_hit_a;
    logic w_hit_b;

    assign w_is_x0 = (i_rd_addr == ADDR_W'(X0_IDX));
    assign w_hit_a = i_wa_en && (i_wa_addr == i_rd_addr);
    assign w_hit_b = i_wb_en && (i_wb_addr == i_rd_addr);

    // Port A carries the younger instruction, so it outranks port B.
    always_comb begin
        if (w_is_x0)
            o_rd_data = '0;
        else if (w_hit_a)
            o_rd_data = i_wa_data;
        else if (w_hit_b)
            o_rd_data = i_wb_data;
        else
            o_rd_data = i_stored;
    end

    assign o_rd_pending = i_pending && !w_hit_a && !w_hit_b && !w_is_x0;
endmodule

// File: rtl/regfile_sb.sv
// Integer register file with two writeback ports, write-through bypass and a
// per-register pending scoreboard used by decode for RAW hazard stalls.
module regfile_sb
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int NR_REG     = NR_XREG,
    parameter int ADDR_W     = XREG_AW,
    parameter int NR_RD      = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_sb_if.slave   rf
);
    logic [DATA_WIDTH-1:0] w_view [NR_REG];
    logic [NR_REG-1:0]     w_pend_view;

    // x0 has no storage: it reads zero and is never pending.
    assign w_view[0]      = '0;
    assign w_pend_view[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NR_REG; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] r_word;
            logic                  r_pend;
            logic                  w_wr_a;
            logic                  w_wr_b;
            logic                  w_iss;

            assign w_wr_a = rf.wa_en  && (rf.wa_addr  == ADDR_W'(gi));
            assign w_wr_b = rf.wb_en  && (rf.wb_addr  == ADDR_W'(gi));
            assign w_iss  = rf.iss_en && (rf.iss_addr == ADDR_W'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n)
                    r_word <= '0;
                else if (w_wr_a)
                    r_word <= rf.wa_data;
                else if (w_wr_b)
                    r_word <= rf.wb_data;
            end

            // Issue beats flush beats writeback: a new producer always wins.
            always_ff @(posedge clk) begin
                if (!rst_n)
                    r_pend <= 1'b0;
                else if (w_iss)
                    r_pend <= 1'b1;
                else if (rf.flush)
                    r_pend <= 1'b0;
                else if (w_wr_a || w_wr_b)
                    r_pend <= 1'b0;
            end

            assign w_view[gi]      = r_word;
            assign w_pend_view[gi] = r_pend;
        end

        for (genvar gi = 0; gi < NR_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;

            assign w_addr = rf.rd_addr[gi*ADDR_W +: ADDR_W];

            regfile_bypass_mux #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_W     (ADDR_W)
            ) u_mux (
                .i_rd_addr    (w_addr),
                .i_wa_en      (rf.wa_en),
                .i_wa_addr    (rf.wa_addr),
                .i_wa_data    (rf.wa_data),
                .i_wb_en      (rf.wb_en),
                .i_wb_addr    (rf.wb_addr),
                .i_wb_data    (rf.wb_data),
                .i_stored     (w_view[w_addr]),
                .i_pending    (w_pend_view[w_addr]),
                .o_rd_data    (rf.rd_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .o_rd_pending (rf.rd_pending[gi])
            );
        end
    endgenerate

    assign rf.any_pending = |w_pend_view;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized test of regfile_sb against an array-based model.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int RD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    logic [DW-1:0] m_mem [NR];
    bit            m_pend [NR];

    regfile_sb_if #(.DATA_WIDTH(DW), .NR_REG(NR), .ADDR_W(AW), .NR_RD(RD)) rf ();

    regfile_sb #(.DATA_WIDTH(DW), .NR_REG(NR), .ADDR_W(AW), .NR_RD(RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Model: reads and pending follow the forwarding rules; state advances at the edge.
    always @(negedge clk) begin : cmp
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        bit            ep;
        bit            any;
        if (chk_en) begin
            for (int k = 0; k < RD; k++) begin
                a = rf.rd_addr[k*AW +: AW];
                if (a == 0)                              ed = '0;
                else if (rf.wa_en && rf.wa_addr == a)    ed = rf.wa_data;
                else if (rf.wb_en && rf.wb_addr == a)    ed = rf.wb_data;
                else                                     ed = m_mem[a];
                ep = (a != 0) && m_pend[a] && !(rf.wa_en && rf.wa_addr == a)
                     && !(rf.wb_en && rf.wb_addr == a);
                chk($sformatf("model_rd_data[%0d] addr=%0d", k, a), rf.rd_data[k*DW +: DW], ed);
                chk($sformatf("model_rd_pending[%0d] addr=%0d", k, a), DW'(rf.rd_pending[k]), DW'(ep));
            end
            any = 1'b0;
            for (int i = 0; i < NR; i++) any |= m_pend[i];
            chk("model_any_pending", DW'(rf.any_pending), DW'(any));
        end
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (rf.wb_en) begin m_mem[rf.wb_addr] = rf.wb_data; m_pend[rf.wb_addr] = 1'b0; end
            if (rf.wa_en) begin m_mem[rf.wa_addr] = rf.wa_data; m_pend[rf.wa_addr] = 1'b0; end
            if (rf.flush) for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
            if (rf.iss_en) m_pend[rf.iss_addr] = 1'b1;
            m_mem[0]  = '0;
            m_pend[0] = 1'b0;
        end
    end

    task automatic idle();
        rf.wa_en = 1'b0; rf.wa_addr = '0; rf.wa_data = '0;
        rf.wb_en = 1'b0; rf.wb_addr = '0; rf.wb_data = '0;
        rf.iss_en = 1'b0; rf.iss_addr = '0; rf.flush = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input int a0, input int a1);
        rf.rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < NR; a++) begin
            cyc(); rd(a, NR - 1 - a); sample();
            chk($sformatf("%s_data0 a=%0d", tag, a), rf.rd_data[DW-1:0], '0);
            chk($sformatf("%s_data1 a=%0d", tag, a), rf.rd_data[2*DW-1:DW], '0);
            chk($sformatf("%s_pend a=%0d", tag, a), DW'(rf.rd_pending), '0);
            chk($sformatf("%s_any a=%0d", tag, a), DW'(rf.any_pending), '0);
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
        idle();
        rd(0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        check_all_zero("reset");

        // Same-cycle bypass of port A, then the stored value.
        cyc(); rf.wa_en = 1; rf.wa_addr = 5; rf.wa_data = 32'hDEADBEEF; rd(5, 0); sample();
        chk("bypass_a", rf.rd_data[DW-1:0], 32'hDEADBEEF);
        cyc(); rd(5, 0); sample();
        chk("stored_x5", rf.rd_data[DW-1:0], 32'hDEADBEEF);

        // A and B collide: A wins in bypass and storage.
        cyc(); rf.wa_en = 1; rf.wa_addr = 7; rf.wa_data = 32'h11;
        rf.wb_en = 1; rf.wb_addr = 7; rf.wb_data = 32'h22; rd(7, 7); sample();
        chk("collide_bypass0", rf.rd_data[DW-1:0], 32'h11);
        chk("collide_bypass1", rf.rd_data[2*DW-1:DW], 32'h11);
        cyc(); rd(7, 5); sample();
        chk("collide_stored", rf.rd_data[DW-1:0], 32'h11);

        // x0 ignores writes and issues.
        cyc(); rf.wa_en = 1; rf.wa_addr = 0; rf.wa_data = 32'hFFFF;
        rf.iss_en = 1; rf.iss_addr = 0; rd(0, 0); sample();
        chk("x0_data", rf.rd_data[DW-1:0], '0);
        chk("x0_pend", DW'(rf.rd_pending[0]), '0);
        cyc(); rd(0, 0); sample();
        chk("x0_any", DW'(rf.any_pending), '0);
        chk("x0_data_after", rf.rd_data[DW-1:0], '0);

        // Scoreboard set / clear / re-issue on x3.
        cyc(); rf.iss_en = 1; rf.iss_addr = 3; rd(3, 0); sample();
        chk("iss_any_registered", DW'(rf.any_pending), '0);
        cyc(); rd(3, 0); sample();
        chk("x3_pend", DW'(rf.rd_pending[0]), 1);
        chk("x3_any", DW'(rf.any_pending), 1);
        cyc(); rf.wb_en = 1; rf.wb_addr = 3; rf.wb_data = 32'h55; rd(3, 0); sample();
        chk("x3_wb_pend", DW'(rf.rd_pending[0]), '0);
        chk("x3_wb_data", rf.rd_data[DW-1:0], 32'h55);
        cyc(); rd(3, 0); sample();
        chk("x3_cleared_any", DW'(rf.any_pending), '0);
        chk("x3_stored", rf.rd_data[DW-1:0], 32'h55);
        cyc(); rf.wa_en = 1; rf.wa_addr = 3; rf.wa_data = 32'h66; rf.iss_en = 1; rf.iss_addr = 3; rd(3, 0); sample();
        cyc(); rd(3, 0); sample();
        chk("x3_reissue_pend", DW'(rf.rd_pending[0]), 1);
        chk("x3_reissue_data", rf.rd_data[DW-1:0], 32'h66);

        // Flush together with an issue leaves only the new destination pending.
        cyc(); rf.iss_en = 1; rf.iss_addr = 4;
        cyc(); rf.iss_en = 1; rf.iss_addr = 9;
        cyc(); rf.flush = 1; rf.iss_en = 1; rf.iss_addr = 12;
        cyc(); rd(12, 4); sample();
        chk("flush_x12", DW'(rf.rd_pending[0]), 1);
        chk("flush_x4", DW'(rf.rd_pending[1]), '0);
        cyc(); rd(9, 3); sample();
        chk("flush_x9_x3", DW'(rf.rd_pending), '0);
        chk("flush_any", DW'(rf.any_pending), 1);

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            int a0, a1;
            cyc();
            rst_n = ($urandom_range(0, 199) != 0);
            rf.wa_en = $urandom_range(0, 1); rf.wa_addr = AW'($urandom_range(0, 15)); rf.wa_data = $urandom;
            rf.wb_en = $urandom_range(0, 1); rf.wb_addr = AW'($urandom_range(0, 15)); rf.wb_data = $urandom;
            rf.iss_en = ($urandom_range(0, 9) < 4); rf.iss_addr = AW'($urandom_range(0, 15));
            rf.flush = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0: a0 = rf.wa_addr;
                1: a0 = rf.wb_addr;
                default: a0 = $urandom_range(0, 15);
            endcase
            a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 31);
            rd(a0, a1);
        end

        // Mid-stream reset with live traffic, then everything reads back clean.
        cyc(); rf.wa_en = 1; rf.wa_addr = 6; rf.wa_data = 32'hABCD; rf.iss_en = 1; rf.iss_addr = 8;
        rst_n = 1'b0; rd(6, 8);
        cyc(); rst_n = 1'b1;
        check_all_zero("midreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
